// File: rtl/rx_frame_classifier_if.sv
// rx_frame_classifier_if: AXI-Stream bundle (tdata/tkeep/tvalid/tlast/tready) used on both sides of rx_frame_classifier.
interface rx_frame_classifier_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;
  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/rx_frame_classifier.sv
// rx_frame_classifier: AXI-Stream register slice that classifies each frame by port rule and magic signature into a result FIFO.
// Define RX_CLS_SIG_EN to build the signature comparators; otherwise res_sig_hit_o is always 0.
module rx_frame_classifier #(
  parameter int          DATA_WIDTH = 256,
  parameter int          KEEP_WIDTH = DATA_WIDTH/8,
  parameter int          PORT_BEAT  = 1,
  parameter int          PORT_LSB   = 224,
  parameter logic [63:0] SIGNATURE  = 64'h89504E470D0A1A0A,
  parameter int          SIG_BEATS  = 4,
  parameter int          NUM_RULES  = 4,
  parameter int          RES_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  rx_frame_classifier_if.slave         s_axis,
  rx_frame_classifier_if.master        m_axis,
  input  logic                         cfg_load_i,
  input  logic [$clog2(NUM_RULES)-1:0] cfg_index_i,
  input  logic [15:0]                  cfg_port_i,
  input  logic [3:0]                   cfg_class_i,
  input  logic                         cfg_enable_i,
  output logic [3:0]                   res_class_o,
  output logic [15:0]                  res_port_o,
  output logic                         res_sig_hit_o,
  output logic [7:0]                   res_beats_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int RW = 29;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic [KEEP_WIDTH-1:0] m_tkeep_q;
  logic                  m_tvalid_q, m_tlast_q;
  logic [7:0]            beat_q, beat_d;
  logic [15:0]           port_q, port_d, cur_port;
  logic [3:0]            class_q, class_d, cur_class;
  logic                  sig_q, sig_d, beat_hit;
  logic                  accept, port_beat, res_full, push, pop;
  logic [KEEP_WIDTH-8:0] sig_match;
  logic [15:0]           rule_port_q [NUM_RULES];
  logic [3:0]            rule_class_q [NUM_RULES];
  logic [NUM_RULES-1:0]  rule_en_q;
  logic [RW-1:0]         fifo_q [RES_DEPTH];
  logic [AW:0]           wr_q, rd_q;
  logic [RW-1:0]         head;
  assign res_full      = (wr_q - rd_q) == (AW+1)'(RES_DEPTH);
  assign res_valid_o   = wr_q != rd_q;
  assign s_axis.tready = (!m_tvalid_q || m_axis.tready) && !res_full;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign push          = accept && s_axis.tlast;
  assign pop           = res_valid_o && res_ready_i;
  assign port_beat     = beat_q == 8'(PORT_BEAT);
  assign cur_port      = s_axis.tdata[PORT_LSB +: 16];
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tkeep  = m_tkeep_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  // Scan downwards so the lowest matching enabled entry is the one left standing.
  always_comb begin
    cur_class = '0;
    for (int i = NUM_RULES-1; i >= 0; i--)
      if (rule_en_q[i] && rule_port_q[i] == cur_port) cur_class = rule_class_q[i];
  end
`ifdef RX_CLS_SIG_EN
  for (genvar k = 0; k <= KEEP_WIDTH-8; k++) begin : g_sig
    assign sig_match[k] = &s_axis.tkeep[k +: 8] && s_axis.tdata[8*k +: 64] == SIGNATURE;
  end
`else
  assign sig_match = {(KEEP_WIDTH-7){SIGNATURE[0] & 1'b0}};
`endif
  assign beat_hit = |sig_match && beat_q < 8'(SIG_BEATS);
  // The *_d values include the current beat, so they double as the record pushed on tlast.
  always_comb begin
    beat_d  = beat_q == 8'hff ? 8'hff : beat_q + 8'd1;
    port_d  = port_beat ? cur_port : port_q;
    class_d = port_beat ? cur_class : class_q;
    sig_d   = sig_q || beat_hit;
  end
  assign head = res_valid_o ? fifo_q[rd_q[AW-1:0]] : '0;
  assign {res_class_o, res_port_o, res_sig_hit_o, res_beats_o} = head;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      beat_q     <= '0;
      port_q     <= '0;
      class_q    <= '0;
      sig_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      rule_en_q  <= '0;
      for (int i = 0; i < NUM_RULES; i++) begin
        rule_port_q[i]  <= '0;
        rule_class_q[i] <= '0;
      end
    end else begin
      if (!m_tvalid_q || m_axis.tready) m_tvalid_q <= accept;
      if (accept) begin
        m_tdata_q <= s_axis.tdata;
        m_tkeep_q <= s_axis.tkeep;
        m_tlast_q <= s_axis.tlast;
        beat_q    <= s_axis.tlast ? '0 : beat_d;
        port_q    <= s_axis.tlast ? '0 : port_d;
        class_q   <= s_axis.tlast ? '0 : class_d;
        sig_q     <= s_axis.tlast ? 1'b0 : sig_d;
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (cfg_load_i) begin
        rule_port_q[cfg_index_i]  <= cfg_port_i;
        rule_class_q[cfg_index_i] <= cfg_class_i;
        rule_en_q[cfg_index_i]    <= cfg_enable_i;
      end
    end
  always_ff @(posedge clk)
    if (push) fifo_q[wr_q[AW-1:0]] <= {class_d, port_d, sig_d, beat_d};
endmodule

// File: tb/tb_rx_frame_classifier.sv
// tb_rx_frame_classifier: directed bench for rx_frame_classifier with a forwarding scoreboard and per-record field checks.
module tb_rx_frame_classifier;
`ifdef RX_CLS_SIG_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif
  localparam logic [63:0] SIG = 64'h89504E470D0A1A0A;
  logic clk, rst_n;
  logic cfg_load_i, cfg_enable_i, res_sig_hit_o, res_valid_o, res_ready_i;
  logic [1:0] cfg_index_i;
  logic [15:0] cfg_port_i, res_port_o;
  logic [3:0] cfg_class_i, res_class_o;
  logic [7:0] res_beats_o;
  logic rand_en;
  int checks = 0, errors = 0;
  logic [288:0] exp_q [$];
  logic prev_acc = 1'b0;
  rx_frame_classifier_if #(.DATA_WIDTH(256)) s_if ();
  rx_frame_classifier_if #(.DATA_WIDTH(256)) m_if ();
  rx_frame_classifier dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if), .m_axis(m_if),
    .cfg_load_i(cfg_load_i), .cfg_index_i(cfg_index_i), .cfg_port_i(cfg_port_i),
    .cfg_class_i(cfg_class_i), .cfg_enable_i(cfg_enable_i),
    .res_class_o(res_class_o), .res_port_o(res_port_o), .res_sig_hit_o(res_sig_hit_o),
    .res_beats_o(res_beats_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) m_if.tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete();
      prev_acc = 1'b0;
    end else begin
      if (prev_acc) chk("lat", m_if.tvalid, 1);
      if (m_if.tvalid && m_if.tready) begin
        chk("fwd_q", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("fwd", {m_if.tlast, m_if.tkeep, m_if.tdata}, exp_q.pop_front());
      end
      prev_acc = s_if.tvalid && s_if.tready;
      if (prev_acc) exp_q.push_back({s_if.tlast, s_if.tkeep, s_if.tdata});
    end
  end
  function automatic logic [255:0] mk(input int i, input int n, input logic [15:0] port, input int sig_at, input int lsb);
    logic [255:0] d = {8{32'h5a5a_0000 | 32'(n << 8) | 32'(i)}};
    if (i == 1) d[239:224] = port;
    if (i == sig_at) d[lsb +: 64] = SIG;
    return d;
  endfunction
  task automatic beat(input logic [255:0] d, input logic [31:0] k, input logic l);
    int n = 0;
    logic acc = 1'b0;
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l; s_if.tvalid = 1'b1;
    while (!acc && n < 200) begin
      #1;
      acc = s_if.tready;
      @(negedge clk);
      n++;
    end
    if (!acc) chk("beat_to", acc, 1);
    s_if.tvalid = 1'b0;
  endtask
  task automatic send_frame(input int n, input logic [15:0] port, input int sig_at, input int lsb, input logic [31:0] keep0);
    for (int i = 0; i < n; i++) beat(mk(i, n, port, sig_at, lsb), i == 0 ? keep0 : 32'hffff_ffff, i == n-1);
  endtask
  task automatic cfg(input logic [1:0] idx, input logic [15:0] p, input logic [3:0] c, input logic en);
    cfg_load_i = 1'b1; cfg_index_i = idx; cfg_port_i = p; cfg_class_i = c; cfg_enable_i = en;
    @(negedge clk);
    cfg_load_i = 1'b0;
  endtask
  task automatic pop_chk(input logic [3:0] c, input logic [15:0] p, input logic s, input logic [7:0] b);
    int n = 0;
    #1;
    while (!res_valid_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("res_valid", res_valid_o, 1);
    chk("res_class", res_class_o, c);
    chk("res_port", res_port_o, p);
    chk("res_sig", res_sig_hit_o, s);
    chk("res_beats", res_beats_o, b);
    @(negedge clk);
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; rand_en = 1'b0; res_ready_i = 1'b0;
    cfg_load_i = 1'b0; cfg_index_i = '0; cfg_port_i = '0; cfg_class_i = '0; cfg_enable_i = 1'b0;
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_mdata", m_if.tdata, 0);
    chk("rst_rvalid", res_valid_o, 0);
    chk("rst_rec", {res_class_o, res_port_o, res_sig_hit_o, res_beats_o}, 0);
    chk("rst_sready", s_if.tready, 1);
    @(negedge clk);
    cfg(0, 16'h0016, 4'd3, 1'b1);
    cfg(1, 16'h0015, 4'd5, 1'b1);
    cfg(2, 16'h0016, 4'd7, 1'b1);
    cfg(3, 16'hdddd, 4'd6, 1'b0);
    send_frame(4, 16'h0016, 1, 16, 32'hffff_ffff);
    #1;
    chk("res_lat", res_valid_o, 1);
    @(negedge clk);
    pop_chk(4'd3, 16'h0016, SIG_EN, 8'd4);
    send_frame(3, 16'h0015, -1, 0, 32'hffff_ffff);
    pop_chk(4'd5, 16'h0015, 1'b0, 8'd3);
    send_frame(3, 16'h0015, 2, 16, 32'hffff_ffff);
    pop_chk(4'd5, 16'h0015, SIG_EN, 8'd3);
    send_frame(6, 16'hdddd, 4, 16, 32'hffff_ffff);
    pop_chk(4'd0, 16'hdddd, 1'b0, 8'd6);
    send_frame(2, 16'h0016, 0, 192, 32'h7fff_ffff);
    pop_chk(4'd3, 16'h0016, 1'b0, 8'd2);
    send_frame(1, 16'h0016, 0, 192, 32'hffff_ffff);
    pop_chk(4'd0, 16'h0000, SIG_EN, 8'd1);
    // Rule rewrite landing on the port beat must not affect that frame.
    beat(mk(0, 2, 16'h0016, -1, 0), 32'hffff_ffff, 1'b0);
    cfg_load_i = 1'b1; cfg_index_i = 2'd0; cfg_port_i = 16'h0016; cfg_class_i = 4'd9; cfg_enable_i = 1'b1;
    beat(mk(1, 2, 16'h0016, -1, 0), 32'hffff_ffff, 1'b1);
    cfg_load_i = 1'b0;
    pop_chk(4'd3, 16'h0016, 1'b0, 8'd2);
    send_frame(2, 16'h0016, -1, 0, 32'hffff_ffff);
    pop_chk(4'd9, 16'h0016, 1'b0, 8'd2);
    send_frame(2, 16'h0016, -1, 0, 32'hffff_ffff);
    send_frame(3, 16'h0015, -1, 0, 32'hffff_ffff);
    send_frame(2, 16'hdddd, -1, 0, 32'hffff_ffff);
    send_frame(2, 16'h0016, -1, 0, 32'hffff_ffff);
    #1;
    chk("full_rdy", s_if.tready, 0);
    @(negedge clk);
    fork
      send_frame(2, 16'h0015, -1, 0, 32'hffff_ffff);
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("stall_rdy", s_if.tready, 0);
        chk("stall_rvalid", res_valid_o, 1);
        @(negedge clk);
        pop_chk(4'd9, 16'h0016, 1'b0, 8'd2);
        #1;
        chk("rdy_after_pop", s_if.tready, 1);
      end
    join
    #1;
    chk("full_again", s_if.tready, 0);
    @(negedge clk);
    pop_chk(4'd5, 16'h0015, 1'b0, 8'd3);
    pop_chk(4'd0, 16'hdddd, 1'b0, 8'd2);
    pop_chk(4'd9, 16'h0016, 1'b0, 8'd2);
    pop_chk(4'd5, 16'h0015, 1'b0, 8'd2);
    #1;
    chk("drained", res_valid_o, 0);
    @(negedge clk);
    rand_en = 1'b1;
    send_frame(5, 16'h0015, -1, 0, 32'hffff_ffff);
    pop_chk(4'd5, 16'h0015, 1'b0, 8'd5);
    send_frame(1, 16'h0015, -1, 0, 32'hffff_ffff);
    pop_chk(4'd0, 16'h0000, 1'b0, 8'd1);
    send_frame(4, 16'h0015, -1, 0, 32'h0000_ffff);
    pop_chk(4'd5, 16'h0015, 1'b0, 8'd4);
    rand_en = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("fwd_left", exp_q.size(), 0);
    @(negedge clk);
    beat(mk(0, 4, 16'h0016, -1, 0), 32'hffff_ffff, 1'b0);
    beat(mk(1, 4, 16'h0016, -1, 0), 32'hffff_ffff, 1'b0);
    s_if.tdata = mk(2, 4, 16'h0016, -1, 0); s_if.tkeep = '1; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mrst_mvalid", m_if.tvalid, 0);
    chk("mrst_mdata", m_if.tdata, 0);
    chk("mrst_rvalid", res_valid_o, 0);
    chk("mrst_rec", {res_class_o, res_port_o, res_sig_hit_o, res_beats_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mrst_norec", res_valid_o, 0);
    @(negedge clk);
    cfg(1, 16'h0015, 4'd5, 1'b1);
    send_frame(2, 16'h0015, -1, 0, 32'hffff_ffff);
    pop_chk(4'd5, 16'h0015, 1'b0, 8'd2);
    send_frame(2, 16'h0016, -1, 0, 32'hffff_ffff);
    pop_chk(4'd0, 16'h0016, 1'b0, 8'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("fwd_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
